silife_wb_loader: RTL and testbench

Wishbone initiator that loads an 8x8 (parameterisable) Game of Life pattern into the silife core and restarts it. Sits on the Wishbone bus as a master facing the silife responder; takes pattern rows from a valid/ready stream (e.g. a UART or SPI front end), pauses the simulation, writes every row word, then writes the control register. Provides board-level pattern upload without the management CPU.

---
 rtl/silife_pkg.sv | 38 +++
 rtl/silife_wb_initiator.sv | 72 +++++++
 rtl/silife_wb_loader.sv | 209 ++++++++++++++++++++
 tb/tb_silife_wb_loader.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/silife_pkg.sv
// Shared definitions for the silife Wishbone pattern loader: FSM states,
// register map offsets and CTRL bit positions.
package silife_pkg;

`ifdef SILIFE_LOADER_VERIFY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PAUSE,
        ST_GET_ROW,
        ST_WR_ROW,
        ST_VERIFY,
        ST_WR_CTRL,
        ST_FINISH
    } loader_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PAUSE,
        ST_GET_ROW,
        ST_WR_ROW,
        ST_WR_CTRL,
        ST_FINISH
    } loader_state_t;
`endif

    localparam logic [31:0] CTRL_OFFSET   = 32'h0000_0000;
    localparam logic [31:0] MATRIX_OFFSET = 32'h0000_1000;

    localparam int CTRL_ENABLE_BIT    = 0;
    localparam int CTRL_INVERT_BIT    = 1;
    localparam int CTRL_CLK_PULSE_BIT = 2;

    // Row words are packed one per 32-bit word starting at the matrix offset.
    function automatic logic [31:0] row_address(input logic [31:0] base, input logic [15:0] row);
        return base + MATRIX_OFFSET + {14'b0, row, 2'b00};
    endfunction

endpackage

// File: rtl/silife_wb_initiator.sv
// Single-transaction classic Wishbone master with a per-transaction ack
// timeout; the loader FSM feeds it one request at a time.
module silife_wb_initiator #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_active,
    output logic        o_ack,
    output logic        o_timeout,
    output logic [31:0] o_rdata,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    input  logic        i_wb_ack,
    input  logic [31:0] i_wb_data
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic          r_active;
    logic          r_we;
    logic [31:0]   r_addr;
    logic [31:0]   r_data;
    logic [CW-1:0] r_count;

    logic w_ack;
    logic w_expire;

    // An ack in the final allowed cycle still completes the transfer.
    assign w_ack    = r_active & i_wb_ack;
    assign w_expire = r_active & ~i_wb_ack & (r_count == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_active <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
            r_count  <= '0;
        end else if (!r_active) begin
            if (i_req) begin
                r_active <= 1'b1;
                r_we     <= i_we;
                r_addr   <= i_addr;
                r_data   <= i_wdata;
                r_count  <= '0;
            end
        end else if (w_ack || w_expire) begin
            r_active <= 1'b0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_active  = r_active;
    assign o_ack     = w_ack;
    assign o_timeout = w_expire;
    assign o_rdata   = i_wb_data;
    assign o_wb_cyc  = r_active;
    assign o_wb_stb  = r_active;
    assign o_wb_we   = r_active & r_we;
    assign o_wb_addr = r_addr;
    assign o_wb_data = r_data;

endmodule

// File: rtl/silife_wb_loader.sv
// Streams an 8x8 Game of Life pattern into silife over Wishbone and restarts it.
// Define SILIFE_LOADER_VERIFY_EN to read back and compare every row before CTRL.
module silife_wb_loader
    import silife_pkg::*;
#(
    parameter int          WIDTH          = 8,
    parameter int          HEIGHT         = 8,
    parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       ctrl_value,
    input  logic             row_valid,
    input  logic [WIDTH-1:0] row_data,
    output logic             row_ready,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             o_wb_cyc,
    output logic             o_wb_stb,
    output logic             o_wb_we,
    output logic [31:0]      o_wb_addr,
    output logic [31:0]      o_wb_data,
    input  logic             i_wb_ack,
    input  logic [31:0]      i_wb_data
);

    localparam int             IW       = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [IW-1:0]  LAST_ROW = IW'(HEIGHT - 1);

    loader_state_t r_state;
    loader_state_t w_next;
    logic [IW-1:0] r_idx;
    logic [2:0]    r_ctrl;
    logic          r_error;

    logic        w_req;
    logic        w_we;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_active;
    logic        w_ack;
    logic        w_timeout;
    logic [31:0] w_rdata;
    logic        w_idx_inc;
    logic        w_idx_clear;
    logic        w_set_error;
    logic [31:0] w_ctrl_word;
    logic        w_unused_rdata;

`ifdef SILIFE_LOADER_VERIFY_EN
    logic [WIDTH-1:0] r_rows [HEIGHT];

    always_ff @(posedge clk) begin
        if (r_state == ST_GET_ROW && row_valid) begin
            r_rows[r_idx] <= row_data;
        end
    end
`endif

    assign w_unused_rdata = ^w_rdata;

    always_comb begin
        w_ctrl_word                     = '0;
        w_ctrl_word[CTRL_ENABLE_BIT]    = r_ctrl[0];
        w_ctrl_word[CTRL_INVERT_BIT]    = r_ctrl[1];
        w_ctrl_word[CTRL_CLK_PULSE_BIT] = r_ctrl[2];
    end

    silife_wb_initiator #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_initiator (
        .clk       (clk),
        .reset     (reset),
        .i_req     (w_req),
        .i_we      (w_we),
        .i_addr    (w_addr),
        .i_wdata   (w_wdata),
        .o_active  (w_active),
        .o_ack     (w_ack),
        .o_timeout (w_timeout),
        .o_rdata   (w_rdata),
        .o_wb_cyc  (o_wb_cyc),
        .o_wb_stb  (o_wb_stb),
        .o_wb_we   (o_wb_we),
        .o_wb_addr (o_wb_addr),
        .o_wb_data (o_wb_data),
        .i_wb_ack  (i_wb_ack),
        .i_wb_data (i_wb_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_ctrl  <= '0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && start) begin
                r_ctrl  <= ctrl_value;
                r_error <= 1'b0;
                r_idx   <= '0;
            end
            if (w_set_error) begin
                r_error <= 1'b1;
            end
            if (w_idx_clear) begin
                r_idx <= '0;
            end else if (w_idx_inc) begin
                r_idx <= r_idx + IW'(1);
            end
        end
    end

    // Requests are launched one cycle ahead of the bus state so stb rises on
    // entry; states entered straight from an ack relaunch once the bus is idle.
    always_comb begin
        w_next      = r_state;
        w_req       = 1'b0;
        w_we        = 1'b1;
        w_addr      = BASE_ADDR + CTRL_OFFSET;
        w_wdata     = '0;
        w_idx_inc   = 1'b0;
        w_idx_clear = 1'b0;
        w_set_error = 1'b0;
        if (w_timeout) begin
            w_next      = ST_IDLE;
            w_set_error = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_req  = 1'b1;
                        w_next = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (w_ack) begin
                        w_next = ST_GET_ROW;
                    end
                end
                ST_GET_ROW: begin
                    if (row_valid) begin
                        w_req   = 1'b1;
                        w_addr  = row_address(BASE_ADDR, 16'(r_idx));
                        w_wdata = 32'(row_data);
                        w_next  = ST_WR_ROW;
                    end
                end
                ST_WR_ROW: begin
                    if (w_ack) begin
                        if (r_idx == LAST_ROW) begin
`ifdef SILIFE_LOADER_VERIFY_EN
                            w_next      = ST_VERIFY;
                            w_idx_clear = 1'b1;
`else
                            w_next      = ST_WR_CTRL;
`endif
                        end else begin
                            w_idx_inc = 1'b1;
                            w_next    = ST_GET_ROW;
                        end
                    end
                end
`ifdef SILIFE_LOADER_VERIFY_EN
                ST_VERIFY: begin
                    if (!w_active) begin
                        w_req  = 1'b1;
                        w_we   = 1'b0;
                        w_addr = row_address(BASE_ADDR, 16'(r_idx));
                    end else if (w_ack) begin
                        if (w_rdata[WIDTH-1:0] != r_rows[r_idx]) begin
                            w_next      = ST_IDLE;
                            w_set_error = 1'b1;
                        end else if (r_idx == LAST_ROW) begin
                            w_next = ST_WR_CTRL;
                        end else begin
                            w_idx_inc = 1'b1;
                        end
                    end
                end
`endif
                ST_WR_CTRL: begin
                    if (!w_active) begin
                        w_req   = 1'b1;
                        w_wdata = w_ctrl_word;
                    end else if (w_ack) begin
                        w_next = ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    w_next = ST_IDLE;
                end
                default: begin
                    w_next = ST_IDLE;
                end
            endcase
        end
    end

    assign row_ready = (r_state == ST_GET_ROW);
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_FINISH);
    assign error     = r_error;

endmodule

// File: tb/tb_silife_wb_loader.sv
// Directed bench for silife_wb_loader: a 1-cycle-ack Wishbone responder with
// row memory, a row stream feeder with optional gap, and a transaction logger.
module tb_silife_wb_loader;

    localparam int          WIDTH    = 8;
    localparam int          HEIGHT   = 8;
    localparam int          TIMEOUT  = 16;
    localparam logic [31:0] BASE     = 32'h3000_0000;
    localparam logic [31:0] ROW_BASE = 32'h3000_1000;
`ifdef SILIFE_LOADER_VERIFY_EN
    localparam int LOAD_LATENCY = 54;
`else
    localparam int LOAD_LATENCY = 30;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  ctrl_value;
    logic        row_valid;
    logic [7:0]  row_data;
    logic        row_ready;
    logic        busy;
    logic        done;
    logic        error;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [31:0] o_wb_addr;
    logic [31:0] o_wb_data;
    logic        i_wb_ack;
    logic [31:0] i_wb_data;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  rows [8];
    logic        tbClear;
    int          feedIdx;
    int          holdRow;
    int          holdCycles;
    int          holdCount;
    logic [31:0] logAddr [16];
    logic [31:0] logData [16];
    int          logN;
    int          readN;
    int          doneCount;
    int          waitCycles;
    int          cycDuringWait;
    int          stbRun;
    int          lastRun;

    logic        respAck;
    logic [31:0] respData;
    logic [7:0]  mem [8];
    logic [31:0] stallAddr;
    int          corruptRow;
    logic        inRange;
    logic [2:0]  rowSel;

    always #5 clk = ~clk;

    silife_wb_loader #(
        .WIDTH          (WIDTH),
        .HEIGHT         (HEIGHT),
        .BASE_ADDR      (BASE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ctrl_value (ctrl_value),
        .row_valid  (row_valid),
        .row_data   (row_data),
        .row_ready  (row_ready),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .o_wb_cyc   (o_wb_cyc),
        .o_wb_stb   (o_wb_stb),
        .o_wb_we    (o_wb_we),
        .o_wb_addr  (o_wb_addr),
        .o_wb_data  (o_wb_data),
        .i_wb_ack   (i_wb_ack),
        .i_wb_data  (i_wb_data)
    );

    // Responder: acks one cycle after stb, never acks stallAddr, can corrupt one row on read.
    assign inRange   = (o_wb_addr >= ROW_BASE) && (o_wb_addr < ROW_BASE + 32'h20);
    assign rowSel    = o_wb_addr[4:2];
    assign i_wb_ack  = respAck;
    assign i_wb_data = respData;

    always @(posedge clk) begin
        if (reset) begin
            respAck  <= 1'b0;
            respData <= '0;
        end else if (o_wb_cyc && o_wb_stb && !respAck && o_wb_addr != stallAddr) begin
            respAck  <= 1'b1;
            respData <= {24'b0, mem[rowSel]} ^ ((inRange && int'(rowSel) == corruptRow) ? 32'h1 : 32'h0);
        end else begin
            respAck <= 1'b0;
        end
        if (o_wb_cyc && o_wb_stb && respAck && o_wb_we && inRange) begin
            mem[rowSel] <= o_wb_data[7:0];
        end
    end

    // Row feeder and bus/handshake monitor.
    assign row_valid = (feedIdx < HEIGHT) && !(feedIdx == holdRow && holdCount < holdCycles);
    assign row_data  = (feedIdx < HEIGHT) ? rows[feedIdx[2:0]] : 8'h00;

    always @(posedge clk) begin
        if (tbClear) begin
            feedIdx       <= 0;
            holdCount     <= 0;
            logN          <= 0;
            readN         <= 0;
            doneCount     <= 0;
            waitCycles    <= 0;
            cycDuringWait <= 0;
            stbRun        <= 0;
            lastRun       <= 0;
        end else begin
            if (row_valid && row_ready) feedIdx <= feedIdx + 1;
            if (feedIdx == holdRow && holdCount < holdCycles) holdCount <= holdCount + 1;
            if (o_wb_cyc && o_wb_stb && i_wb_ack) begin
                if (o_wb_we) begin
                    if (logN < 16) begin
                        logAddr[logN] <= o_wb_addr;
                        logData[logN] <= o_wb_data;
                    end
                    logN <= logN + 1;
                end else begin
                    readN <= readN + 1;
                end
            end
            if (done) doneCount <= doneCount + 1;
            if (row_ready && !row_valid) waitCycles <= waitCycles + 1;
            if (row_ready && !row_valid && o_wb_cyc) cycDuringWait <= cycDuringWait + 1;
            if (o_wb_stb) begin
                stbRun <= stbRun + 1;
            end else begin
                if (stbRun != 0) lastRun <= stbRun;
                stbRun <= 0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic [2:0] ctrl);
        @(negedge clk);
        start      = st;
        ctrl_value = ctrl;
    endtask

    task automatic clearBench();
        @(negedge clk);
        tbClear = 1'b1;
        @(negedge clk);
        tbClear = 1'b0;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_flags"}, {57'b0, o_wb_cyc, o_wb_stb, o_wb_we, row_ready, busy, done, error}, 64'h0);
        checkOutput({tag, "_addr"}, o_wb_addr, 64'h0);
        checkOutput({tag, "_data"}, o_wb_data, 64'h0);
    endtask

    // Starts a load and waits (bounded) for done or error; cycles counts edges from start sampling.
    task automatic runLoad(input logic [2:0] ctrl, output int cycles, output bit finished);
        applyStimulus(1'b1, ctrl);
        cycles   = 0;
        finished = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            cycles++;
            if (i == 0) start = 1'b0;
            if (done) begin
                finished = 1'b1;
                break;
            end
            if (i > 0 && error) break;
        end
    endtask

    task automatic checkWrites(input string tag, input logic [2:0] ctrl);
        checkOutput({tag, "_count"}, 64'(logN), 64'd10);
        checkOutput({tag, "_pauseAddr"}, logAddr[0], BASE);
        checkOutput({tag, "_pauseData"}, logData[0], 64'h0);
        for (int r = 0; r < HEIGHT; r++) begin
            checkOutput($sformatf("%s_row%0dAddr", tag, r), logAddr[r+1], ROW_BASE + 32'(4 * r));
            checkOutput($sformatf("%s_row%0dData", tag, r), logData[r+1], {56'b0, rows[r]});
        end
        checkOutput({tag, "_ctrlAddr"}, logAddr[9], BASE);
        checkOutput({tag, "_ctrlData"}, logData[9], {61'b0, ctrl});
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  cycles;
        bit  finished;
        bit  found;

        reset      = 1'b1;
        start      = 1'b1;
        ctrl_value = 3'b111;
        tbClear    = 1'b1;
        holdRow    = -1;
        holdCycles = 0;
        stallAddr  = 32'h0;
        corruptRow = -1;
        for (int r = 0; r < 8; r++) rows[r] = 8'(1 << r);

        // Reset held with start asserted: everything quiet.
        repeat (3) begin
            @(posedge clk);
            #1;
            checkIdleOutputs("rstHold");
        end
        @(negedge clk);
        reset   = 1'b0;
        start   = 1'b0;
        tbClear = 1'b0;

        // Basic load of a walking-one pattern.
        clearBench();
        runLoad(3'b001, cycles, finished);
        checkOutput("basicFinished", 64'(finished), 64'd1);
        checkOutput("basicLatency", 64'(cycles), 64'(LOAD_LATENCY));
        checkOutput("basicError", 64'(error), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("basicDoneCount", 64'(doneCount), 64'd1);
        checkOutput("basicBusy", 64'(busy), 64'd0);
        checkWrites("basic", 3'b001);
`ifdef SILIFE_LOADER_VERIFY_EN
        checkOutput("basicReads", 64'(readN), 64'd8);
`endif

        // Row 3 withheld for 20 cycles; ctrl_value changes mid-load and must be ignored.
        for (int r = 0; r < 8; r++) rows[r] = 8'(8'h3C ^ (r * 17));
        holdRow    = 3;
        holdCycles = 20;
        clearBench();
        fork
            runLoad(3'b110, cycles, finished);
            begin
                repeat (5) @(negedge clk);
                ctrl_value = 3'b001;
            end
        join
        checkOutput("gapFinished", 64'(finished), 64'd1);
        checkOutput("gapWaitCycles", 64'(waitCycles), 64'd18);
        checkOutput("gapCycDuringWait", 64'(cycDuringWait), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("gapDoneCount", 64'(doneCount), 64'd1);
        checkWrites("gap", 3'b110);
        holdRow    = -1;
        holdCycles = 0;

        // Extra start while busy, then reset during the row 4 write.
        for (int r = 0; r < 8; r++) rows[r] = 8'(r + 1);
        clearBench();
        applyStimulus(1'b1, 3'b011);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        applyStimulus(1'b1, 3'b111);
        @(posedge clk);
        #1;
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (o_wb_stb && o_wb_addr == ROW_BASE + 32'h10) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("row4Reached", 64'(found), 64'd1);
        checkOutput("busyStartWrites", 64'(logN), 64'd5);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkIdleOutputs("midRst");
        @(negedge clk);
        reset = 1'b0;
        clearBench();
        runLoad(3'b101, cycles, finished);
        checkOutput("restartFinished", 64'(finished), 64'd1);
        checkOutput("restartLatency", 64'(cycles), 64'(LOAD_LATENCY));
        repeat (2) @(posedge clk);
        #1;
        checkWrites("restart", 3'b101);

        // Responder never acks row 5: timeout, sticky error, no CTRL write.
        for (int r = 0; r < 8; r++) rows[r] = 8'(r * 3 + 5);
        stallAddr = ROW_BASE + 32'h14;
        clearBench();
        runLoad(3'b001, cycles, finished);
        checkOutput("toFinished", 64'(finished), 64'd0);
        checkOutput("toError", 64'(error), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("toBusy", 64'(busy), 64'd0);
        checkOutput("toStb", 64'(o_wb_stb), 64'd0);
        checkOutput("toStbCycles", 64'(lastRun), 64'(TIMEOUT));
        checkOutput("toDoneCount", 64'(doneCount), 64'd0);
        checkOutput("toWrites", 64'(logN), 64'd6);
        checkOutput("toErrorSticky", 64'(error), 64'd1);
        stallAddr = 32'h0;

        // Next load clears the error and completes.
        clearBench();
        runLoad(3'b100, cycles, finished);
        checkOutput("recoverFinished", 64'(finished), 64'd1);
        checkOutput("recoverError", 64'(error), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        checkWrites("recover", 3'b100);

`ifdef SILIFE_LOADER_VERIFY_EN
        // Corrupted readback of row 2 aborts before the CTRL write.
        corruptRow = 2;
        clearBench();
        runLoad(3'b001, cycles, finished);
        checkOutput("vfyBadFinished", 64'(finished), 64'd0);
        checkOutput("vfyBadError", 64'(error), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("vfyBadReads", 64'(readN), 64'd3);
        checkOutput("vfyBadWrites", 64'(logN), 64'd9);
        checkOutput("vfyBadBusy", 64'(busy), 64'd0);
        corruptRow = -1;
        clearBench();
        runLoad(3'b011, cycles, finished);
        checkOutput("vfyGoodFinished", 64'(finished), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("vfyGoodReads", 64'(readN), 64'd8);
        checkWrites("vfyGood", 3'b011);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
